mac_operand_fifo: RTL

Operand buffer between the BF16 operand file reader and the BF16 MAC datapath. It captures each {A, B, C} operand triple presented by the reader. The triples are queued in a small synchronous FIFO and offered to the MAC with a valid/ready handshake. This decouples MAC pipeline stalls from the reader, which streams one triple per clock and has no backpressure.

---
 rtl/mac_operand_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mac_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_fifo
// Description : Show-ahead operand FIFO between the BF16 operand file reader
//               and the BF16 MAC datapath. Each entry is one {A, B, C} triple.
//               The reader cannot stall, so a triple offered while the FIFO is
//               full is dropped and a sticky overflow flag is raised.
//               Optional macro HWM_EN adds a high-water mark output 'hwm'.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [15:0]       in_a,
    input  logic [15:0]       in_b,
    input  logic [31:0]       in_c,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_a,
    output logic [15:0]       out_b,
    output logic [31:0]       out_c,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [31:0]       push_total
`ifdef HWM_EN
    ,
    output logic [ADDR_W:0]   hwm
`endif
);

    localparam logic [ADDR_W:0]   c_full    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

    // Entry layout: {A[63:48], B[47:32], C[31:0]}
    logic [63:0]       mem [DEPTH];

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       push_total_q, push_total_d;

    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [63:0]       w_head;

    // Handshake decode; flush suppresses push, pop and drop alike
    always_comb begin
        out_valid = (count_q != '0);
        in_ready  = (count_q != c_full) | out_ready;
        w_push    = in_valid & in_ready & ~flush;
        w_pop     = out_valid & out_ready & ~flush;
        w_drop    = in_valid & ~in_ready & ~flush;
    end

    // Next-state computation for pointers, occupancy and status
    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        push_total_d = push_total_q;
        if (flush) begin
            wp_d       = '0;
            rp_d       = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_push) begin
                wp_d         = wp_q + c_ptr_one;
                push_total_d = push_total_q + 32'd1;
            end
            if (w_pop) begin
                rp_d = rp_q + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + c_cnt_one;
            end else if (w_pop && !w_push) begin
                count_d = count_q - c_cnt_one;
            end
            if (w_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state registers, cleared asynchronously by RST
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            push_total_q <= '0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            push_total_q <= push_total_d;
        end
    end

    // Storage array; contents need no reset since out_* are masked when empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[wp_q] <= {in_a, in_b, in_c};
        end
    end

    // Show-ahead head entry, zeroed while empty to match the reader idle value
    always_comb begin
        w_head = out_valid ? mem[rp_q] : 64'd0;
        out_a  = w_head[63:48];
        out_b  = w_head[47:32];
        out_c  = w_head[31:0];
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign push_total = push_total_q;

`ifdef HWM_EN
    logic [ADDR_W:0] hwm_q;

    // High-water mark tracks the largest occupancy reached since reset/flush
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            hwm_q <= '0;
        end else if (flush) begin
            hwm_q <= '0;
        end else if (count_d > hwm_q) begin
            hwm_q <= count_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule
`default_nettype wire
